calc_ctrl: RTL
==============

Name: calc_ctrl

Overview:
- Sequencing controller that sits directly upstream of the 5-bit result register (load / shift-right / shift-left / hold).
- Accepts one arithmetic command at a time via a start/busy/done handshake.
- Drives the register's data input and 2-bit op code, and reads the register output back to compute the next value.
- Supports ADD, SUB, SHL-by-N, SHR-by-N and MUL. MUL is shift-and-add that uses the result register as the accumulator.

Parameters:
- W, 5, data width; must equal result-register width.
- NW, 3, width of shift-count field taken from b[NW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  command request; sampled only in IDLE.
- opcode  in  3  000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 MUL, others illegal.
- a  in  W  operand A.
- b  in  W  operand B / shift count.
- reg_q  in  W  result-register output (fed back).
- reg_d  out  W  result-register data input.
- op_reg  out  2  00 hold, 01 load, 10 shift right, 11 shift left.
- busy  out  1  high from the cycle after start is accepted until DONE completes.
- done  out  1  one-cycle pulse; reg_q holds the final result in this cycle.
- ovf  out  1  valid with done; sticky over the command.
- err  out  1  valid with done; illegal opcode.

Behaviour:
- Reset: one clock (clk), asynchronous active-low reset (rst), as already decided.
  - Asserting rst at any time forces IDLE and clears internal registers.
  - Outputs go to op_reg=00, reg_d=0, busy=0, done=0, ovf=0, err=0.
  - Reset mid-command abandons the command; no done is produced.
- Outputs are Moore: they are functions of state and internal registers only, never of start.
- IDLE: op_reg=00. If start=1 at a rising edge, capture opcode, a, b into a_q, b_q, cnt; clear ovf/err; go to LOAD. An illegal opcode goes to DONE with err=1 instead, and reg_q is left untouched.
- start while busy is ignored.
- LOAD (op_reg=01), by opcode:
  - ADD: reg_d=(a_q+b_q) mod 2^W; ovf=carry out.
  - SUB: reg_d=(a_q-b_q) mod 2^W; ovf=borrow (a_q<b_q).
  - SHL/SHR: reg_d=a_q; cnt=b_q[NW-1:0].
  - MUL: reg_d=0; bit index i=W-1.
- Next state after LOAD:
  - ADD/SUB go to DONE.
  - SHL/SHR go to SHIFT if cnt≠0, else DONE.
  - MUL goes to MSHL.
- SHIFT: op_reg=11 (SHL) or 10 (SHR) for cnt cycles; cnt decrements each cycle; at cnt=1 go to DONE.
  - SHL: ovf |= reg_q[W-1] each cycle.
  - A count of W or more yields 0.
- MSHL: op_reg=11; ovf |= reg_q[W-1].
  - If b_q[i]=1, go to MADD.
  - Else if i=0, go to DONE; else decrement i and stay in MSHL.
- MADD: op_reg=01, reg_d=reg_q+a_q mod 2^W; ovf |= carry. Then go to DONE if i=0, else decrement i and go to MSHL.
- DONE: op_reg=00, done=1, busy=0; go to IDLE. Back-to-back: start is accepted in the IDLE cycle immediately after done.
- Latency from the start-sampling edge to done:
  - ADD/SUB: 2 cycles.
  - SHL/SHR: 2+N cycles.
  - MUL: 2+W+popcount(b) cycles.
  - Illegal opcode: 1 cycle.
- All arithmetic is unsigned and truncated to W bits.

Optional Feature:
- CALC_CTRL_SAT_EN
  - Defined: if ovf=1 when the last compute state ends, go through an extra SAT state before DONE. SAT drives op_reg=01, with reg_d all-ones (ADD/SHL/MUL) or 0 (SUB). This adds 1 cycle.
  - Undefined: no SAT state; results wrap and ovf only flags the overflow.

Decomposition:
- Package calc_pkg holds:
  - opcode constants (OP_ADD..OP_MUL);
  - op_reg encodings (REG_HOLD=00, REG_LOAD=01, REG_SHR=10, REG_SHL=11);
  - state enum (IDLE, LOAD, SHIFT, MSHL, MADD, SAT, DONE).
- One combinational sub-module, calc_addsub: W-bit add/sub with carry/borrow out. It is shared by LOAD and MADD.

Test Plan (bench models the result register behind reg_d/op_reg):
- ADD a=12, b=9 -> done 2 cycles after start, reg_q=21, ovf=0. ADD a=20, b=15 -> reg_q=3, ovf=1 (saturate build: reg_q=31).
- SUB a=5, b=7 -> reg_q=30, ovf=1 (saturate build: reg_q=0). SUB a=7, b=5 -> reg_q=2, ovf=0.
- SHL a=5'b00111, b=2 -> done at 4 cycles, reg_q=5'b11100, ovf=0. SHL a=5'b10001, b=1 -> reg_q=5'b00010, ovf=1. SHR a=22, b=0 -> done at 2 cycles, reg_q=22.
- MUL a=5, b=6 -> done at 2+5+2=9 cycles, reg_q=30, ovf=0. MUL a=7, b=7 -> reg_q=17, ovf=1.
- Illegal opcode=111 -> done 1 cycle after start, err=1, reg_q unchanged. start pulsed while busy during MUL -> ignored, single done.
- rst deasserted→asserted mid-MUL (MSHL, i=2) -> all outputs 0 immediately, no done. After release, ADD 1+1 -> reg_q=2.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcodes, result-register op encodings and controller states for calc_ctrl.
// No logic of its own; imported by the controller.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [1:0] REG_HOLD = 2'b00;
  localparam logic [1:0] REG_LOAD = 2'b01;
  localparam logic [1:0] REG_SHR  = 2'b10;
  localparam logic [1:0] REG_SHL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    MSHL,
    MADD,
    SAT,
    DONE
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/calc_addsub.sv
// W-bit unsigned add/subtract with carry (add) or borrow (sub) out; purely combinational.
// Zero latency, no handshake: the caller owns operand selection and timing.
module calc_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         co
);

  logic [W:0] r;

  // The extra top bit is the carry for an add and the borrow for a subtract.
  always_comb begin
    r = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
  end

  assign sum = r[W-1:0];
  assign co  = r[W];

endmodule

// File: rtl/calc_ctrl.sv
// Sequencer driving an external W-bit load/shift register for ADD/SUB/SHL/SHR/MUL; one command at a time via start/busy/done.
// Latency 2 (ADD/SUB), 2+N (shifts), 2+W+popcount(b) (MUL), 1 (illegal); CALC_CTRL_SAT_EN adds a saturating SAT cycle on overflow.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int W  = 5,
  parameter int NW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    opcode,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  reg_q,
  output logic [W-1:0]  reg_d,
  output logic [1:0]    op_reg,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          err
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  state_t         state, state_n;
  logic [2:0]     op_q, op_n;
  logic [W-1:0]   a_q, a_n;
  logic [W-1:0]   b_q, b_n;
  logic [NW-1:0]  cnt, cnt_n;
  logic [IW-1:0]  idx, idx_n;
  logic           ovf_q, ovf_n;
  logic           err_q, err_n;
  logic           last;

  logic [W-1:0]   as_x, as_y, as_sum;
  logic           as_sub, as_co;

  // One adder serves both LOAD (a op b) and MADD (accumulator + a).
  always_comb begin
    as_x   = a_q;
    as_y   = b_q;
    as_sub = (op_q == OP_SUB);
    if (state == MADD) begin
      as_x   = reg_q;
      as_y   = a_q;
      as_sub = 1'b0;
    end
  end

  calc_addsub #(.W(W)) u_addsub (
    .x   (as_x),
    .y   (as_y),
    .sub (as_sub),
    .sum (as_sum),
    .co  (as_co)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      idx   <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      a_q   <= a_n;
      b_q   <= b_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      ovf_q <= ovf_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    cnt_n   = cnt;
    idx_n   = idx;
    ovf_n   = ovf_q;
    err_n   = err_q;
    last    = 1'b0;
    reg_d   = '0;
    op_reg  = REG_HOLD;
    busy    = 1'b0;
    done    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          op_n    = opcode;
          a_n     = a;
          b_n     = b;
          cnt_n   = b[NW-1:0];
          ovf_n   = 1'b0;
          err_n   = !op_legal(opcode);
          state_n = op_legal(opcode) ? LOAD : DONE;
        end
      end

      LOAD: begin
        busy   = 1'b1;
        op_reg = REG_LOAD;
        case (op_q)
          OP_ADD, OP_SUB: begin
            reg_d = as_sum;
            ovf_n = as_co;
            last  = 1'b1;
          end
          OP_SHL, OP_SHR: begin
            reg_d = a_q;
            if (cnt == '0) last = 1'b1;
            else           state_n = SHIFT;
          end
          default: begin
            reg_d   = '0;
            idx_n   = IW'(W - 1);
            state_n = MSHL;
          end
        endcase
      end

      SHIFT: begin
        busy   = 1'b1;
        op_reg = (op_q == OP_SHL) ? REG_SHL : REG_SHR;
        if (op_q == OP_SHL) ovf_n = ovf_q | reg_q[W-1];
        cnt_n = cnt - NW'(1);
        if (cnt == NW'(1)) last = 1'b1;
      end

      // MSB-first shift-and-add; the external register is the accumulator.
      MSHL: begin
        busy   = 1'b1;
        op_reg = REG_SHL;
        ovf_n  = ovf_q | reg_q[W-1];
        if (b_q[idx])        state_n = MADD;
        else if (idx == '0)  last = 1'b1;
        else                 idx_n = idx - IW'(1);
      end

      MADD: begin
        busy   = 1'b1;
        op_reg = REG_LOAD;
        reg_d  = as_sum;
        ovf_n  = ovf_q | as_co;
        if (idx == '0) begin
          last = 1'b1;
        end else begin
          idx_n   = idx - IW'(1);
          state_n = MSHL;
        end
      end

      SAT: begin
        busy    = 1'b1;
        op_reg  = REG_LOAD;
        reg_d   = (op_q == OP_SUB) ? '0 : '1;
        state_n = DONE;
      end

      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Overflow is judged including this final cycle's contribution.
    if (last) begin
`ifdef CALC_CTRL_SAT_EN
      state_n = ovf_n ? SAT : DONE;
`else
      state_n = DONE;
`endif
    end
  end

  assign ovf = ovf_q;
  assign err = err_q;

endmodule
